// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipe_stage_buf_pkg
// Purpose  : Shared types for the pipelined core's stage registers: per-stage
//            bundle structs (IF/ID, ID/EX, EX/MEM, MEM/WB), their NOP bubble
//            constants used as the stage reset/empty value, and the skid
//            buffer occupancy state type.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_stage_buf_pkg;

    // Occupancy of the 2-entry skid stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } ifid_t;

    typedef struct packed {
        opcode_t     opcode;
        aluop_t      aluop;
        logic [31:0] npc;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [4:0]  wsel;
        logic        regwen;
        logic        memren;
        logic        memwen;
        logic        halt;
    } idex_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [31:0] npc;
        logic [31:0] alu_out;
        logic [31:0] wdat;
        logic [4:0]  wsel;
        logic        regwen;
        logic        memren;
        logic        memwen;
        logic        halt;
    } exmem_t;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] alu_out;
        logic [31:0] dload;
        logic [4:0]  wsel;
        logic        regwen;
        logic        memtoreg;
        logic        halt;
    } memwb_t;

    // All-zero bundles decode as RTYPE / ALU_SLL with every write enable
    // low, i.e. a harmless "sll r0,r0,0" bubble.
    localparam ifid_t  IFID_NOP  = '0;
    localparam idex_t  IDEX_NOP  = '0;
    localparam exmem_t EXMEM_NOP = '0;
    localparam memwb_t MEMWB_NOP = '0;

endpackage : pipe_stage_buf_pkg
`default_nettype wire

// File: rtl/pipe_stage_buf_entry.sv
`default_nettype none
// ============================================================================
// Module   : pipe_entry
// Purpose  : One stage-buffer slot: a DATA_W payload register plus valid bit.
//            clear_i has priority over load_i. The payload is forced back to
//            RST_VAL whenever the slot empties, so an invalid slot never
//            exposes stale data.
// Ports    : CLK, nRST (async, active-low)
//            load_i  - capture d_i, mark valid
//            clear_i - mark invalid, payload <= RST_VAL
//            d_i     - payload in
//            valid_o - slot holds a bundle
//            data_o  - payload (RST_VAL when invalid)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_entry #(
    parameter int                 DATA_W  = 128,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] d_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            data_q  <= RST_VAL;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_entry
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Generic pipeline-stage register with valid/ready handshake,
//            global advance qualifier (en), qualified flush (flush_q, only
//            with en) and unqualified flush (flush_now). SKID=0 gives a
//            single-entry latch with combinational in_ready; SKID=1 gives a
//            2-entry skid buffer whose in_ready comes straight from a flop.
// Ports    : CLK, nRST (async, active-low)
//            en, flush_now, flush_q        - advance / flush controls
//            in_valid, in_ready, in_data   - upstream side
//            out_valid, out_ready, out_data- downstream side
//            occ                           - entries held (0..2)
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int                DATA_W  = 128,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int                SKID    = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush_now,
    input  logic              flush_q,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              w_push;
    logic              w_pop;
    logic              w_kill;

    logic              w_h_load;
    logic              w_h_clear;
    logic [DATA_W-1:0] w_h_d;
    logic              w_h_valid;
    logic [DATA_W-1:0] w_h_data;

    assign w_kill = flush_now | (flush_q & en);
    assign w_push = en & in_valid & in_ready;
    assign w_pop  = en & w_h_valid & out_ready;

    // Head entry (entry 0) exists in both modes
    pipe_entry #(
        .DATA_W  (DATA_W),
        .RST_VAL (RST_VAL)
    ) u_head (
        .CLK     (CLK),
        .nRST    (nRST),
        .load_i  (w_h_load),
        .clear_i (w_h_clear),
        .d_i     (w_h_d),
        .valid_o (w_h_valid),
        .data_o  (w_h_data)
    );

    assign out_valid = w_h_valid;
    assign out_data  = w_h_data;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_t       state_q;
            logic              in_ready_q;
            logic              w_s_load;
            logic              w_s_clear;
            logic              w_s_valid;
            logic [DATA_W-1:0] w_s_data;

            // Occupancy FSM; in_ready is registered alongside the state so
            // the upstream stall path never sees a combinational input.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else if (w_kill) begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (w_push) begin
                                state_q <= ONE;
                            end
                        end
                        ONE: begin
                            if (w_push && !w_pop) begin
                                state_q    <= FULL;
                                in_ready_q <= 1'b0;
                            end else if (w_pop && !w_push) begin
                                state_q <= EMPTY;
                            end
                        end
                        FULL: begin
                            if (w_pop) begin
                                state_q    <= ONE;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= EMPTY;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end

            // Head refills from the skid slot when draining FULL, otherwise
            // directly from upstream.
            assign w_h_load  = ~w_kill &
                               ((w_push & ((state_q == EMPTY) | ((state_q == ONE) & w_pop))) |
                                (w_pop & (state_q == FULL)));
            assign w_h_d     = (state_q == FULL) ? w_s_data : in_data;
            assign w_h_clear = w_kill | (w_pop & ~w_push & (state_q == ONE));

            assign w_s_load  = ~w_kill & w_push & ~w_pop & (state_q == ONE);
            assign w_s_clear = w_kill | (w_pop & (state_q == FULL));

            pipe_entry #(
                .DATA_W  (DATA_W),
                .RST_VAL (RST_VAL)
            ) u_skid (
                .CLK     (CLK),
                .nRST    (nRST),
                .load_i  (w_s_load),
                .clear_i (w_s_clear),
                .d_i     (in_data),
                .valid_o (w_s_valid),
                .data_o  (w_s_data)
            );

            assign in_ready = in_ready_q;
            // Skid is only ever occupied behind a valid head
            assign occ      = {w_s_valid, w_h_valid & ~w_s_valid};
        end else begin : g_latch
            assign in_ready  = ~w_h_valid | out_ready;
            assign w_h_d     = in_data;
            assign w_h_load  = ~w_kill & w_push;
            // Push+pop replaces the entry, so only a lone pop empties it
            assign w_h_clear = w_kill | (w_pop & ~w_push);
            assign occ       = {1'b0, w_h_valid};
        end
    endgenerate

endmodule : pipe_stage_buf
`default_nettype wire
